// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Optional signed mode: define SEQ_BIN2BCD_SIGNED_EN.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   in_valid   in   input word valid
//   in_ready   out  converter idle, accepts a word
//   bin_in     in   BIN_W-bit binary value
//   out_valid  out  result available
//   out_ready  in   consumer takes the result
//   bcd_out    out  DIGITS packed BCD digits, ones digit in [3:0]
//   overflow   out  value needed more than DIGITS digits
//   neg        out  input was negative (signed mode only)
module seq_bin2bcd #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  neg
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic                 neg_q, neg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [BIN_W-1:0]     mag;
    logic                 sgn;
    logic [4*DIGITS-1:0]  adj;

`ifdef SEQ_BIN2BCD_SIGNED_EN
    // Two's complement magnitude; the most negative value maps to
    // 2^(BIN_W-1), which still fits as an unsigned BIN_W-bit word.
    assign sgn = bin_in[BIN_W-1];
    assign mag = sgn ? (BIN_W'(0) - bin_in) : bin_in;
`else
    assign sgn = 1'b0;
    assign mag = bin_in;
`endif

    // Add 3 to each digit >= 5 so the following shift carries correctly.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bin_d   = mag;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    neg_d   = sgn;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A bit leaving the top digit means the value no
                // longer fits; low digits keep the truncated result.
                bcd_d = {adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                ovf_d = ovf_q | adj[4*DIGITS-1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
    assign neg      = neg_q;

endmodule
